// File: rtl/msrv32_alu_pkg.sv
// Integer ALU opcode encodings and legality check, shared by decode and the ALU arbiter.
// Also holds the response-register state type used by the arbiter.
package msrv32_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

  function automatic logic is_legal_alu_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
      ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/msrv32_rr_arb2.sv
// Two-way combinational grant with a round-robin pointer; FIXED_PRIO makes req0 always win.
// The pointer moves only on a fire where both requesters competed.
module msrv32_rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic fire,
  output logic grant0,
  output logic grant1
);

  logic prio_ptr;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && valid1) begin
      if ((FIXED_PRIO != 0) || !prio_ptr) grant0 = 1'b1;
      else                                grant1 = 1'b1;
    end else if (valid0) begin
      grant0 = 1'b1;
    end else if (valid1) begin
      grant1 = 1'b1;
    end
  end

  // Point at the loser so it wins the next contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          prio_ptr <= 1'b0;
    else if (fire && valid0 && valid1)   prio_ptr <= ~grant1;
  end

endmodule

// File: rtl/msrv32_alu_arbiter.sv
// Shares one integer ALU between execute (req0) and branch/agen (req1); result is captured
// into a one-entry response register visible the cycle after the fire; full and stalled blocks both requesters.
module msrv32_alu_arbiter
  import msrv32_alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            req0_valid_in,
  output logic            req0_ready_out,
  input  logic [XLEN-1:0] req0_op_1_in,
  input  logic [XLEN-1:0] req0_op_2_in,
  input  logic [3:0]      req0_opcode_in,
  input  logic            req1_valid_in,
  output logic            req1_ready_out,
  input  logic [XLEN-1:0] req1_op_1_in,
  input  logic [XLEN-1:0] req1_op_2_in,
  input  logic [3:0]      req1_opcode_in,
  output logic [XLEN-1:0] alu_op_1_out,
  output logic [XLEN-1:0] alu_op_2_out,
  output logic [3:0]      alu_opcode_out,
  input  logic [XLEN-1:0] alu_result_in,
  output logic            rsp_valid_out,
  input  logic            rsp_ready_in,
  output logic            rsp_id_out,
  output logic [XLEN-1:0] rsp_result_out,
  output logic            rsp_err_out
);

  rsp_state_t state, state_nxt;
  logic       can_accept;
  logic       grant0, grant1;
  logic       fire;
  logic       op_legal;

  msrv32_rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .valid0 (req0_valid_in),
    .valid1 (req1_valid_in),
    .fire   (fire),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign can_accept = (state == RSP_EMPTY) || rsp_ready_in;

  // Reset gates ready so no handshake completes while reset is held.
  assign req0_ready_out = grant0 && can_accept && rst_n_in;
  assign req1_ready_out = grant1 && can_accept && rst_n_in;
  assign fire           = req0_ready_out || req1_ready_out;

  always_comb begin
    alu_op_1_out   = req0_op_1_in;
    alu_op_2_out   = req0_op_2_in;
    alu_opcode_out = req0_opcode_in;
    if (grant1) begin
      alu_op_1_out   = req1_op_1_in;
      alu_op_2_out   = req1_op_2_in;
      alu_opcode_out = req1_opcode_in;
    end
  end

  assign op_legal = is_legal_alu_op(alu_opcode_out);

  always_comb begin
    state_nxt = state;
    case (state)
      RSP_EMPTY: if (fire) state_nxt = RSP_FULL;
      RSP_FULL:  if (!fire && rsp_ready_in) state_nxt = RSP_EMPTY;
      default:   state_nxt = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= RSP_EMPTY;
    else           state <= state_nxt;
  end

  assign rsp_valid_out = (state == RSP_FULL);

  // Illegal opcodes capture zero so an undefined ALU output never escapes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rsp_id_out     <= 1'b0;
      rsp_result_out <= '0;
      rsp_err_out    <= 1'b0;
    end else if (fire) begin
      rsp_id_out     <= grant1;
      rsp_result_out <= op_legal ? alu_result_in : '0;
      rsp_err_out    <= !op_legal;
    end
  end

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// Bench for msrv32_alu_arbiter: directed vector table, random traffic against a reference
// model, plus fixed-priority and asynchronous-reset sequences on a second instance.
module tb_msrv32_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0, v1, rsp_rdy;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  c0, c1;

  logic        r0, r1, rv, rid, rerr;
  logic [31:0] ao1, ao2, rres, alu_res;
  logic [3:0]  aoc;

  logic        f_r0, f_r1, f_rv, f_rid, f_rerr;
  logic [31:0] f_ao1, f_ao2, f_rres, f_alu_res;
  logic [3:0]  f_aoc;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0100: return a ^ b;
      4'b0001: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic legal_op(input logic [3:0] op);
    return op inside {4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
                      4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101};
  endfunction

  assign alu_res   = alu_ref(aoc, ao1, ao2);
  assign f_alu_res = alu_ref(f_aoc, f_ao1, f_ao2);

  msrv32_alu_arbiter #(.XLEN(32), .FIXED_PRIO(0)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req0_valid_in(v0), .req0_ready_out(r0), .req0_op_1_in(a0), .req0_op_2_in(b0), .req0_opcode_in(c0),
    .req1_valid_in(v1), .req1_ready_out(r1), .req1_op_1_in(a1), .req1_op_2_in(b1), .req1_opcode_in(c1),
    .alu_op_1_out(ao1), .alu_op_2_out(ao2), .alu_opcode_out(aoc), .alu_result_in(alu_res),
    .rsp_valid_out(rv), .rsp_ready_in(rsp_rdy), .rsp_id_out(rid), .rsp_result_out(rres), .rsp_err_out(rerr)
  );

  msrv32_alu_arbiter #(.XLEN(32), .FIXED_PRIO(1)) dut_fp (
    .clk_in(clk), .rst_n_in(rst_n),
    .req0_valid_in(v0), .req0_ready_out(f_r0), .req0_op_1_in(a0), .req0_op_2_in(b0), .req0_opcode_in(c0),
    .req1_valid_in(v1), .req1_ready_out(f_r1), .req1_op_1_in(a1), .req1_op_2_in(b1), .req1_opcode_in(c1),
    .alu_op_1_out(f_ao1), .alu_op_2_out(f_ao2), .alu_opcode_out(f_aoc), .alu_result_in(f_alu_res),
    .rsp_valid_out(f_rv), .rsp_ready_in(rsp_rdy), .rsp_id_out(f_rid), .rsp_result_out(f_rres), .rsp_err_out(f_rerr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v0, v1;
    logic [3:0]  c0;
    logic [31:0] a0, b0;
    logic [3:0]  c1;
    logic [31:0] a1, b1;
    logic        rdy;
    logic        e_r0, e_r1, e_v, e_id;
    logic [31:0] e_res;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic iv0, input logic iv1,
                              input logic [3:0] ic0, input logic [31:0] ia0, input logic [31:0] ib0,
                              input logic [3:0] ic1, input logic [31:0] ia1, input logic [31:0] ib1,
                              input logic irdy, input logic er0, input logic er1, input logic ev,
                              input logic eid, input logic [31:0] eres, input logic eerr);
    vec_t t;
    t.v0 = iv0; t.v1 = iv1; t.c0 = ic0; t.a0 = ia0; t.b0 = ib0;
    t.c1 = ic1; t.a1 = ia1; t.b1 = ib1; t.rdy = irdy;
    t.e_r0 = er0; t.e_r1 = er1; t.e_v = ev; t.e_id = eid; t.e_res = eres; t.e_err = eerr;
    return t;
  endfunction

  localparam int NV = 14;
  vec_t vecs[NV];

  // Reference model state for the random phase
  logic        m_full, m_id, m_err, m_ptr, w, acc, fire;
  logic [31:0] m_res;

  initial begin
    vecs[0]  = mk(1, 0, 4'b0000, 5, 7, 4'b0000, 0, 0, 1,                       1, 0, 1, 0, 32'd12, 0);
    vecs[1]  = mk(1, 1, 4'b1000, 9, 4, 4'b0100, 32'hF0, 32'h0F, 1,             1, 0, 1, 0, 32'd5, 0);
    vecs[2]  = mk(1, 1, 4'b1000, 9, 4, 4'b0100, 32'hF0, 32'h0F, 1,             0, 1, 1, 1, 32'hFF, 0);
    vecs[3]  = mk(1, 1, 4'b1000, 9, 4, 4'b0100, 32'hF0, 32'h0F, 1,             1, 0, 1, 0, 32'd5, 0);
    vecs[4]  = mk(1, 1, 4'b1000, 9, 4, 4'b0100, 32'hF0, 32'h0F, 1,             0, 1, 1, 1, 32'hFF, 0);
    vecs[5]  = mk(1, 0, 4'b0000, 1, 2, 4'b0000, 0, 0, 0,                       0, 0, 1, 1, 32'hFF, 0);
    vecs[6]  = mk(1, 0, 4'b0000, 1, 2, 4'b0000, 0, 0, 0,                       0, 0, 1, 1, 32'hFF, 0);
    vecs[7]  = mk(1, 0, 4'b0000, 1, 2, 4'b0000, 0, 0, 0,                       0, 0, 1, 1, 32'hFF, 0);
    vecs[8]  = mk(1, 0, 4'b0000, 1, 2, 4'b0000, 0, 0, 1,                       1, 0, 1, 0, 32'd3, 0);
    vecs[9]  = mk(0, 1, 4'b0000, 0, 0, 4'b1111, 3, 4, 1,                       0, 1, 1, 1, 32'd0, 1);
    vecs[10] = mk(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 1,                       0, 0, 0, 0, 32'd0, 0);
    vecs[11] = mk(0, 1, 4'b0000, 0, 0, 4'b0010, 32'hFFFF_FFFF, 1, 1,           0, 1, 1, 1, 32'd1, 0);
    vecs[12] = mk(1, 1, 4'b1101, 32'h8000_0000, 4, 4'b0011, 1, 2, 1,           1, 0, 1, 0, 32'hF800_0000, 0);
    vecs[13] = mk(1, 1, 4'b1101, 32'h8000_0000, 4, 4'b0011, 1, 2, 1,           0, 1, 1, 1, 32'd1, 0);

    // Reset held with both requesters asking
    v0 = 1; v1 = 1; rsp_rdy = 1;
    a0 = 1; b0 = 1; c0 = 4'b0000; a1 = 2; b1 = 2; c1 = 4'b0000;
    repeat (2) @(posedge clk);
    #2;
    chk("reset rsp_valid", 32'(rv), 0);
    chk("reset ready0", 32'(r0), 0);
    chk("reset ready1", 32'(r1), 0);
    chk("reset result", rres, 0);
    chk("reset fp ready0", 32'(f_r0), 0);
    v0 = 0; v1 = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      v0 = vecs[i].v0; v1 = vecs[i].v1; rsp_rdy = vecs[i].rdy;
      c0 = vecs[i].c0; a0 = vecs[i].a0; b0 = vecs[i].b0;
      c1 = vecs[i].c1; a1 = vecs[i].a1; b1 = vecs[i].b1;
      #1;
      chk($sformatf("vec%0d ready0", i), 32'(r0), 32'(vecs[i].e_r0));
      chk($sformatf("vec%0d ready1", i), 32'(r1), 32'(vecs[i].e_r1));
      @(posedge clk); #1;
      chk($sformatf("vec%0d rsp_valid", i), 32'(rv), 32'(vecs[i].e_v));
      if (vecs[i].e_v) begin
        chk($sformatf("vec%0d rsp_id", i), 32'(rid), 32'(vecs[i].e_id));
        chk($sformatf("vec%0d rsp_result", i), rres, vecs[i].e_res);
        chk($sformatf("vec%0d rsp_err", i), 32'(rerr), 32'(vecs[i].e_err));
      end
    end

    // Clean restart, then random traffic against the model
    v0 = 0; v1 = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    m_full = 0; m_id = 0; m_res = 0; m_err = 0; m_ptr = 0;
    for (int n = 0; n < 400; n++) begin
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      rsp_rdy = ($urandom_range(0, 3) != 0);
      a0 = $urandom; b0 = $urandom; c0 = 4'($urandom_range(0, 15));
      a1 = $urandom; b1 = $urandom; c1 = 4'($urandom_range(0, 15));
      #1;
      acc  = !m_full || rsp_rdy;
      w    = (v0 && v1) ? m_ptr : (v1 && !v0);
      fire = acc && (v0 || v1);
      chk("rand ready0", 32'(r0), 32'(acc && v0 && !w));
      chk("rand ready1", 32'(r1), 32'(acc && v1 && w));
      chk("rand alu_op_1", ao1, w ? a1 : a0);
      chk("rand alu_opcode", 32'(aoc), 32'(w ? c1 : c0));
      @(posedge clk); #1;
      if (fire) begin
        m_full = 1;
        m_id   = w;
        m_err  = !legal_op(w ? c1 : c0);
        m_res  = m_err ? 32'd0 : (w ? alu_ref(c1, a1, b1) : alu_ref(c0, a0, b0));
        if (v0 && v1) m_ptr = !w;
      end else if (rsp_rdy) begin
        m_full = 0;
      end
      chk("rand rsp_valid", 32'(rv), 32'(m_full));
      if (m_full) begin
        chk("rand rsp_id", 32'(rid), 32'(m_id));
        chk("rand rsp_result", rres, m_res);
        chk("rand rsp_err", 32'(rerr), 32'(m_err));
      end
    end

    // Fixed priority: req0 wins every contended cycle
    v0 = 0; v1 = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      v0 = 1; v1 = 1; rsp_rdy = 1;
      c0 = 4'b0000; a0 = 32'(k); b0 = 1;
      c1 = 4'b0100; a1 = 32'hF0; b1 = 32'h0F;
      #1;
      chk("fp ready0", 32'(f_r0), 1);
      chk("fp ready1", 32'(f_r1), 0);
      @(posedge clk); #1;
      chk("fp rsp_id", 32'(f_rid), 0);
      chk("fp rsp_result", f_rres, 32'(k + 1));
    end

    // Asynchronous reset while full drops rsp_valid before the next edge
    v0 = 0; v1 = 0; rsp_rdy = 0;
    #2;
    chk("fp full before reset", 32'(f_rv), 1);
    rst_n = 0;
    #1;
    chk("async reset fp rsp_valid", 32'(f_rv), 0);
    chk("async reset rsp_valid", 32'(rv), 0);
    chk("async reset fp result", f_rres, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
